// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared encodings for the ID/EX issue stage and the bit-slice ALU:
//   - alu_op_e   : 3-bit slice opcode {aluop2,aluop1,aluop0}. Bit 2 doubles as
//                  the bit-0 carry-in, so SUB/SLT inject the +1 of two's complement.
//   - ctrl_aluop_e : 2-bit main-control ALUOp.
//   - FUNCT_*    : R-type funct field codes understood by the decoder.
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        CTRL_ADD   = 2'b00,  // lw / sw address generation
        CTRL_SUB   = 2'b01,  // beq compare
        CTRL_RTYPE = 2'b10,  // operation taken from funct
        CTRL_ORI   = 2'b11   // ori, zero-extended immediate
    } ctrl_aluop_e;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ----------------------------------------------------------------------------
// alu_ctrl_decode
//   Combinational ALU control: translates main-control ALUOp plus the R-type
//   funct field into the 3-bit slice opcode.
//   Ports:
//     ctrl_aluop in  2  main-control ALUOp
//     funct      in  6  instr[5:0]
//     aluop      out 3  slice opcode {aluop2,aluop1,aluop0}
//     illegal    out 1  R-type funct not supported (opcode falls back to ADD)
// ----------------------------------------------------------------------------
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ctrl_aluop,
    input  logic [5:0] funct,
    output logic [2:0] aluop,
    output logic       illegal
);

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        aluop   = ALU_ADD;
        illegal = 1'b0;
        unique case (ctrl_aluop)
            CTRL_ADD: aluop = ALU_ADD;
            CTRL_SUB: aluop = ALU_SUB;
            CTRL_ORI: aluop = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: aluop = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU: aluop = ALU_SUB;
                    FUNCT_AND:             aluop = ALU_AND;
                    FUNCT_OR:              aluop = ALU_OR;
                    FUNCT_SLT:             aluop = ALU_SLT;
                    default: begin
                        aluop   = ALU_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ----------------------------------------------------------------------------
// id_ex_alu_issue
//   ID/EX pipeline register in front of the 32-bit bit-slice ALU. Captures the
//   decoded instruction, resolves ALU control, builds A/B operands and carries
//   the memory/writeback control bits. Valid/ready on both sides, with flush.
//
//   Build option: define ALU_FWD_EN to enable MEM/WB operand forwarding at
//   capture. Without it the fwd_* ports are present but ignored.
//
//   Ports:
//     clk, reset_n                   clock, async active-low reset
//     in_valid / in_ready            ID-side handshake
//     ctrl_aluop, funct, alusrc, imm decoded control and immediate
//     rs_num, rt_num, rs_data, rt_data  source registers and read data
//     dst, regwrite, memread, memwrite, memtoreg  carried-through control
//     flush                          kill the entry (branch taken)
//     out_valid / out_ready          EX-side handshake
//     ex_a, ex_b, ex_aluop, ex_store ALU operands, slice opcode, store data
//     ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal
//     fwd_{mem,wb}_{we,dst,data}     forwarding sources
// ----------------------------------------------------------------------------
module id_ex_alu_issue
    import alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ctrl_aluop,
    input  logic [5:0]      funct,
    input  logic            alusrc,
    input  logic [15:0]     imm,
    input  logic [REGW-1:0] rs_num,
    input  logic [REGW-1:0] rt_num,
    input  logic [W-1:0]    rs_data,
    input  logic [W-1:0]    rt_data,
    input  logic [REGW-1:0] dst,
    input  logic            regwrite,
    input  logic            memread,
    input  logic            memwrite,
    input  logic            memtoreg,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    ex_a,
    output logic [W-1:0]    ex_b,
    output logic [2:0]      ex_aluop,
    output logic [W-1:0]    ex_store,
    output logic [REGW-1:0] ex_dst,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_illegal,
    input  logic            fwd_mem_we,
    input  logic            fwd_wb_we,
    input  logic [REGW-1:0] fwd_mem_dst,
    input  logic [REGW-1:0] fwd_wb_dst,
    input  logic [W-1:0]    fwd_mem_data,
    input  logic [W-1:0]    fwd_wb_data
);

    // Reset asserts asynchronously but releases on a clock edge, so no flop
    // sees reset_n rise close to the clock.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [W-1:0] rs_op;
    logic [W-1:0] rt_op;

`ifdef ALU_FWD_EN
    // MEM is younger than WB, so it wins when both target the same register.
    // Register 0 is hard-wired to zero and is never forwarded.
    function automatic logic [W-1:0] fwd_sel(input logic [REGW-1:0] num,
                                             input logic [W-1:0]    rf_data);
        if (fwd_mem_we && fwd_mem_dst == num && num != '0) return fwd_mem_data;
        if (fwd_wb_we  && fwd_wb_dst  == num && num != '0) return fwd_wb_data;
        return rf_data;
    endfunction

    assign rs_op = fwd_sel(rs_num, rs_data);
    assign rt_op = fwd_sel(rt_num, rt_data);
`else
    logic unused_fwd;
    assign rs_op      = rs_data;
    assign rt_op      = rt_data;
    assign unused_fwd = ^{fwd_mem_we, fwd_wb_we, fwd_mem_dst, fwd_wb_dst,
                          fwd_mem_data, fwd_wb_data, rs_num, rt_num};
`endif

    // ori zero-extends; every other immediate use sign-extends.
    logic [W-1:0] imm_ext;
    logic [W-1:0] b_op;

    always_comb begin
        if (ctrl_aluop == CTRL_ORI) imm_ext = {{(W-16){1'b0}}, imm};
        else                        imm_ext = {{(W-16){imm[15]}}, imm};
    end
    assign b_op = alusrc ? imm_ext : rt_op;

    // ------------------------------------------------------------------
    // ALU control
    // ------------------------------------------------------------------
    logic [2:0] dec_aluop;
    logic       dec_illegal;

    alu_ctrl_decode u_decode (
        .ctrl_aluop (ctrl_aluop),
        .funct      (funct),
        .aluop      (dec_aluop),
        .illegal    (dec_illegal)
    );

    // ------------------------------------------------------------------
    // Handshake and pipeline register
    // ------------------------------------------------------------------
    logic capture;

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            out_valid   <= 1'b0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_aluop    <= '0;
            ex_store    <= '0;
            ex_dst      <= '0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (flush) begin
            // Kill wins over a same-cycle capture; side-effecting controls are
            // cleared so a stray consumer cannot write state.
            out_valid   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            ex_a        <= rs_op;
            ex_b        <= b_op;
            ex_aluop    <= dec_aluop;
            ex_store    <= rt_op;
            ex_dst      <= dst;
            ex_regwrite <= regwrite && !dec_illegal;
            ex_memread  <= memread;
            ex_memwrite <= memwrite && !dec_illegal;
            ex_memtoreg <= memtoreg;
            ex_illegal  <= dec_illegal;
        end else if (out_ready) begin
            // Downstream took the entry and nothing replaced it.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// ----------------------------------------------------------------------------
// tb_id_ex_alu_issue
//   Directed bench for id_ex_alu_issue. Expected entries are built from the
//   instruction at the moment it is accepted, queued, and compared against the
//   EX-side outputs while they are presented. Follows ALU_FWD_EN like the RTL.
// ----------------------------------------------------------------------------
module tb_id_ex_alu_issue;

    localparam int W    = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      ctrl_aluop;
    logic [5:0]      funct;
    logic            alusrc;
    logic [15:0]     imm;
    logic [REGW-1:0] rs_num, rt_num, dst;
    logic [W-1:0]    rs_data, rt_data;
    logic            regwrite, memread, memwrite, memtoreg;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    ex_a, ex_b, ex_store;
    logic [2:0]      ex_aluop;
    logic [REGW-1:0] ex_dst;
    logic            ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;
    logic            fwd_mem_we, fwd_wb_we;
    logic [REGW-1:0] fwd_mem_dst, fwd_wb_dst;
    logic [W-1:0]    fwd_mem_data, fwd_wb_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [2:0]      aluop;
        logic [W-1:0]    store;
        logic [REGW-1:0] dst;
        logic            rw, mr, mw, mtr, ill;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    id_ex_alu_issue #(.W(W), .REGW(REGW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ctrl_aluop   (ctrl_aluop),
        .funct        (funct),
        .alusrc       (alusrc),
        .imm          (imm),
        .rs_num       (rs_num),
        .rt_num       (rt_num),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .dst          (dst),
        .regwrite     (regwrite),
        .memread      (memread),
        .memwrite     (memwrite),
        .memtoreg     (memtoreg),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_aluop     (ex_aluop),
        .ex_store     (ex_store),
        .ex_dst       (ex_dst),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_memtoreg  (ex_memtoreg),
        .ex_illegal   (ex_illegal),
        .fwd_mem_we   (fwd_mem_we),
        .fwd_wb_we    (fwd_wb_we),
        .fwd_mem_dst  (fwd_mem_dst),
        .fwd_wb_dst   (fwd_wb_dst),
        .fwd_mem_data (fwd_mem_data),
        .fwd_wb_data  (fwd_wb_data)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference operand value, following the forwarding rules when enabled.
    function automatic logic [W-1:0] ref_operand(input logic [REGW-1:0] num, input logic [W-1:0] data);
`ifdef ALU_FWD_EN
        if (fwd_mem_we && fwd_mem_dst == num && num != 0) return fwd_mem_data;
        if (fwd_wb_we && fwd_wb_dst == num && num != 0) return fwd_wb_data;
`endif
        return data;
    endfunction

    // Reference entry for the instruction currently on the ID-side inputs.
    function automatic exp_t ref_entry();
        exp_t e;
        logic ill;
        logic [W-1:0] rt_v;
        ill = 1'b0;
        case (ctrl_aluop)
            2'b00: e.aluop = 3'b010;
            2'b01: e.aluop = 3'b110;
            2'b11: e.aluop = 3'b001;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: e.aluop = 3'b010;
                    6'b100010, 6'b100011: e.aluop = 3'b110;
                    6'b100100:            e.aluop = 3'b000;
                    6'b100101:            e.aluop = 3'b001;
                    6'b101010:            e.aluop = 3'b111;
                    default: begin e.aluop = 3'b010; ill = 1'b1; end
                endcase
            end
        endcase
        rt_v    = ref_operand(rt_num, rt_data);
        e.a     = ref_operand(rs_num, rs_data);
        if (!alusrc)                e.b = rt_v;
        else if (ctrl_aluop == 2'b11) e.b = {16'h0000, imm};
        else                        e.b = {{16{imm[15]}}, imm};
        e.store = rt_v;
        e.dst   = dst;
        e.rw    = regwrite & ~ill;
        e.mr    = memread;
        e.mw    = memwrite & ~ill;
        e.mtr   = memtoreg;
        e.ill   = ill;
        return e;
    endfunction

    task automatic compare_entry(input exp_t e);
        check("out_valid",   {31'b0, out_valid},   32'd1);
        check("ex_a",        ex_a,                 e.a);
        check("ex_b",        ex_b,                 e.b);
        check("ex_aluop",    {29'b0, ex_aluop},    {29'b0, e.aluop});
        check("ex_store",    ex_store,             e.store);
        check("ex_dst",      {27'b0, ex_dst},      {27'b0, e.dst});
        check("ex_regwrite", {31'b0, ex_regwrite}, {31'b0, e.rw});
        check("ex_memread",  {31'b0, ex_memread},  {31'b0, e.mr});
        check("ex_memwrite", {31'b0, ex_memwrite}, {31'b0, e.mw});
        check("ex_memtoreg", {31'b0, ex_memtoreg}, {31'b0, e.mtr});
        check("ex_illegal",  {31'b0, ex_illegal},  {31'b0, e.ill});
    endtask

    // One clock: predict handshake from the model, advance, then compare.
    task automatic step();
        logic mvalid, cap, cons;
        exp_t e;
        #1;
        mvalid = (sb.size() != 0);
        check("in_ready", {31'b0, in_ready}, {31'b0, (!mvalid || out_ready)});
        cons = mvalid && out_ready;
        cap  = in_valid && (!mvalid || out_ready);
        if (cap) e = ref_entry();
        @(posedge clk);
        #1;
        if (flush) begin
            sb.delete();
            check("flush_valid",    {31'b0, out_valid},   32'd0);
            check("flush_regwrite", {31'b0, ex_regwrite}, 32'd0);
            check("flush_memread",  {31'b0, ex_memread},  32'd0);
            check("flush_memwrite", {31'b0, ex_memwrite}, 32'd0);
        end else begin
            if (cons) void'(sb.pop_front());
            if (cap) sb.push_back(e);
            if (sb.size() != 0) compare_entry(sb[0]);
            else check("idle_valid", {31'b0, out_valid}, 32'd0);
        end
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic src,
                         input logic [15:0] im, input logic [REGW-1:0] rsn, input logic [W-1:0] rsd,
                         input logic [REGW-1:0] rtn, input logic [W-1:0] rtd, input logic [REGW-1:0] d,
                         input logic rw, input logic mr, input logic mw, input logic mtr);
        in_valid = 1'b1; ctrl_aluop = op; funct = fn; alusrc = src; imm = im;
        rs_num = rsn; rs_data = rsd; rt_num = rtn; rt_data = rtd; dst = d;
        regwrite = rw; memread = mr; memwrite = mw; memtoreg = mtr;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        ctrl_aluop = '0; funct = '0; alusrc = 1'b0; imm = '0;
        rs_num = '0; rt_num = '0; rs_data = '0; rt_data = '0; dst = '0;
        regwrite = 1'b0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0; fwd_mem_dst = '0; fwd_wb_dst = '0;
        fwd_mem_data = '0; fwd_wb_data = '0;

        // Reset state
        #2;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ex_a",      ex_a,               32'd0);
        check("rst_ex_b",      ex_b,               32'd0);
        check("rst_ex_aluop",  {29'b0, ex_aluop},  32'd0);
        check("rst_ex_store",  ex_store,           32'd0);
        check("rst_ex_illegal",{31'b0, ex_illegal},32'd0);
        #20 reset_n = 1'b1;
        @(posedge clk); #1;
        idle(3);

        // R-type add, then a back-to-back run of R-type ops
        instr(2'b10, 6'b100000, 1'b0, 16'h0000, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1, 0, 0, 0);
        step();
        instr(2'b10, 6'b100010, 1'b0, 16'h0000, 5'd4, 32'h100, 5'd6, 32'h1, 5'd8, 1, 0, 0, 0);
        step();
        instr(2'b10, 6'b100100, 1'b0, 16'h1234, 5'd9, 32'hF0F0_F0F0, 5'd10, 32'h0FF0_0FF0, 5'd11, 1, 0, 0, 0);
        step();
        instr(2'b10, 6'b100101, 1'b0, 16'h0000, 5'd12, 32'hA5A5_0000, 5'd13, 32'h0000_5A5A, 5'd14, 1, 0, 0, 0);
        step();
        instr(2'b01, 6'b000000, 1'b0, 16'h0004, 5'd15, 32'd3, 5'd16, 32'd3, 5'd0, 0, 0, 0, 0);
        step();
        idle(1);

        // Immediates: ori zero-extends, lw/sw sign-extend
        instr(2'b11, 6'b111111, 1'b1, 16'hFFFF, 5'd1, 32'h1000_0000, 5'd2, 32'h5555_5555, 5'd2, 1, 0, 0, 0);
        step();
        instr(2'b00, 6'b111100, 1'b1, 16'hFFFC, 5'd29, 32'h0000_8000, 5'd7, 32'hDEAD_BEEF, 5'd7, 1, 1, 0, 1);
        step();
        instr(2'b00, 6'b000000, 1'b1, 16'h0008, 5'd29, 32'h0000_8000, 5'd7, 32'hCAFE_F00D, 5'd0, 0, 0, 1, 0);
        step();
        idle(1);

        // SLT held for 3 stalled cycles while the next instruction waits
        out_ready = 1'b0;
        instr(2'b10, 6'b101010, 1'b0, 16'h0000, 5'd3, 32'hFFFF_FFFF, 5'd4, 32'd1, 5'd5, 1, 0, 0, 0);
        step();
        instr(2'b10, 6'b100001, 1'b0, 16'h0000, 5'd6, 32'd40, 5'd7, 32'd2, 5'd8, 1, 0, 0, 0);
        step(); step(); step();
        out_ready = 1'b1;
        step();
        idle(1);

        // Flush in the same cycle as a sw capture
        instr(2'b00, 6'b000000, 1'b1, 16'h0010, 5'd29, 32'h200, 5'd9, 32'h77, 5'd0, 0, 0, 1, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle(1);

        // Unsupported funct, plus subu
        instr(2'b10, 6'b100111, 1'b0, 16'h0000, 5'd1, 32'd11, 5'd2, 32'd22, 5'd3, 1, 0, 1, 0);
        step();
        instr(2'b10, 6'b100011, 1'b0, 16'h0000, 5'd1, 32'd11, 5'd2, 32'd22, 5'd3, 1, 0, 0, 0);
        step();
        idle(1);

        // Forwarding: MEM beats WB, r0 never forwarded, WB-only on rt
        fwd_mem_we = 1'b1; fwd_mem_dst = 5'd3; fwd_mem_data = 32'd9;
        fwd_wb_we  = 1'b1; fwd_wb_dst  = 5'd3; fwd_wb_data  = 32'd4;
        instr(2'b10, 6'b100000, 1'b0, 16'h0000, 5'd3, 32'd100, 5'd5, 32'd200, 5'd6, 1, 0, 0, 0);
        step();
        fwd_mem_dst = 5'd0; fwd_wb_dst = 5'd0;
        instr(2'b10, 6'b100000, 1'b0, 16'h0000, 5'd0, 32'd0, 5'd5, 32'd200, 5'd6, 1, 0, 0, 0);
        step();
        fwd_mem_dst = 5'd1; fwd_wb_dst = 5'd5; fwd_wb_data = 32'h0BAD_0BAD;
        instr(2'b00, 6'b000000, 1'b1, 16'h0020, 5'd4, 32'h400, 5'd5, 32'd200, 5'd0, 0, 0, 1, 0);
        step();
        fwd_mem_we = 1'b0; fwd_wb_we = 1'b0;
        idle(1);

        // Reset asserted while an entry is held
        out_ready = 1'b0;
        instr(2'b10, 6'b100101, 1'b0, 16'h0000, 5'd1, 32'h1234_5678, 5'd2, 32'h9ABC_DEF0, 5'd3, 1, 1, 1, 1);
        step();
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst7_out_valid", {31'b0, out_valid},   32'd0);
        check("rst7_ex_a",      ex_a,                 32'd0);
        check("rst7_ex_b",      ex_b,                 32'd0);
        check("rst7_ex_aluop",  {29'b0, ex_aluop},    32'd0);
        check("rst7_ex_store",  ex_store,             32'd0);
        check("rst7_ex_dst",    {27'b0, ex_dst},      32'd0);
        check("rst7_regwrite",  {31'b0, ex_regwrite}, 32'd0);
        check("rst7_memwrite",  {31'b0, ex_memwrite}, 32'd0);
        sb.delete();
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
